// File: rtl/flow_event_sequencer.sv
// Decode-stage control-flow sequencer. A single prioritised FSM steps the
// pipeline through CALL, RET, RTI and external-interrupt sequences and drives
// the stall, second-iteration, flush and stack push/pop strobes. It yields to
// the load-use hazard while idle.
module flow_event_sequencer #(
  parameter int unsigned FLUSH_CYCLES = 1  // legal range 1..3
) (
  input  logic Clk,
  input  logic Rst,
  input  logic int_req,
  input  logic call_dec,
  input  logic ret_dec,
  input  logic rti_dec,
  input  logic load_use,
  output logic stall,
  output logic second_iter,
  output logic flush,
  output logic push_pc,
  output logic push_flags,
  output logic pop_pc,
  output logic pop_flags,
  output logic int_ack,
  output logic busy
);

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StCPush = 3'd1,
    StRPop  = 3'd2,
    StTFl   = 3'd3,
    StTPc   = 3'd4,
    StIPc   = 3'd5,
    StIFg   = 3'd6,
    StFl    = 3'd7
  } state_e;

  localparam logic [1:0] FlushLoad = 2'(FLUSH_CYCLES);

  state_e     state_q, state_d;
  logic       int_pend_q, int_pend_d;
  logic       int_req_q;
  logic [1:0] flush_cnt_q, flush_cnt_d;
  logic       req_edge;
  logic       take_int;

  assign req_edge = int_req & ~int_req_q;

  // Next state: arbitration in idle, fixed micro-sequences elsewhere.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    take_int    = 1'b0;
    case (state_q)
      StIdle: begin
        // A load-use stall re-presents the decode instruction, so ignore it now.
        if (!load_use) begin
          if (rti_dec) begin
            state_d = StTFl;
          end else if (ret_dec) begin
            state_d = StRPop;
          end else if (call_dec) begin
            state_d = StCPush;
          end else if (int_pend_q) begin
            state_d  = StIPc;
            take_int = 1'b1;
          end
        end
      end
      StTFl: state_d = StTPc;
      StIPc: state_d = StIFg;
      StCPush, StRPop, StTPc, StIFg: begin
        state_d     = StFl;
        flush_cnt_d = FlushLoad;
      end
      StFl: begin
        if (flush_cnt_q <= 2'd1) begin
          state_d = StIdle;
        end else begin
          flush_cnt_d = flush_cnt_q - 2'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Pending interrupt: a new edge wins over the clear when both happen together.
  always_comb begin
    int_pend_d = (int_pend_q & ~take_int) | req_edge;
  end

  // State registers.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q     <= StIdle;
      int_pend_q  <= 1'b0;
      int_req_q   <= 1'b0;
      flush_cnt_q <= 2'd0;
    end else begin
      state_q     <= state_d;
      int_pend_q  <= int_pend_d;
      int_req_q   <= int_req;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Moore output decode; only the idle stall follows load_use directly.
  always_comb begin
    stall       = 1'b0;
    second_iter = 1'b0;
    flush       = 1'b0;
    push_pc     = 1'b0;
    push_flags  = 1'b0;
    pop_pc      = 1'b0;
    pop_flags   = 1'b0;
    int_ack     = 1'b0;
    busy        = (state_q != StIdle);
    case (state_q)
      StIdle:  stall = load_use & Rst;  // reset forces every output low
      StCPush: begin
        stall   = 1'b1;
        push_pc = 1'b1;
      end
      StRPop: begin
        stall  = 1'b1;
        pop_pc = 1'b1;
      end
      StTFl: begin
        stall     = 1'b1;
        pop_flags = 1'b1;
      end
      StTPc: begin
        stall       = 1'b1;
        pop_pc      = 1'b1;
        second_iter = 1'b1;
      end
      StIPc: begin
        stall   = 1'b1;
        push_pc = 1'b1;
        int_ack = 1'b1;
      end
      StIFg: begin
        stall       = 1'b1;
        push_flags  = 1'b1;
        second_iter = 1'b1;
      end
      StFl: begin
        stall = 1'b1;
        flush = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
